bps_sequencer: RTL and testbench

Parametrised successor to the single-channel BPS master. It drives one shared 3-bit opcode bus to `CHANNELS` bps engines and runs a full belief-propagation job: LOAD, then N iterations of DOWN/UP, then optional STORE_DOWN/STORE_UP. Each opcode issues only after every enabled engine has released its stall. The block sits between host control (start/abort) and the bps array, and replaces the fixed-sequence master.

---
 rtl/bps_pkg.sv | 28 ++
 rtl/bps_sequencer.sv | 133 +++++++++++++
 tb/tb_bps_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bps_pkg.sv
// Shared opcode constants for the bps engines and the sequencer FSM encoding.
package bps_pkg;

    localparam logic [2:0] OP_IDLE       = 3'd0;
    localparam logic [2:0] OP_LOAD       = 3'd1;
    localparam logic [2:0] OP_DOWN       = 3'd2;
    localparam logic [2:0] OP_UP         = 3'd3;
    localparam logic [2:0] OP_STORE_DOWN = 3'd4;
    localparam logic [2:0] OP_STORE_UP   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BLANK = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // First store op enabled by the mask, or OP_IDLE when the job ends without stores.
    function automatic logic [2:0] first_store(input logic [1:0] mask);
        if (mask[0])
            return OP_STORE_DOWN;
        else if (mask[1])
            return OP_STORE_UP;
        else
            return OP_IDLE;
    endfunction

endpackage

// File: rtl/bps_sequencer.sv
// Belief-propagation job sequencer: issues LOAD, DOWN/UP passes and stores on a
// shared opcode bus, waiting for every enabled engine to drop its stall between ops.
module bps_sequencer
    import bps_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int ITER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ITER_WIDTH-1:0] iterations,
    input  logic [1:0]            store_mask,
    input  logic [CHANNELS-1:0]   channel_en,
    input  logic [CHANNELS-1:0]   bps_stall,
    output logic                  stall,
    output logic [2:0]            opcode,
    output logic                  done,
    output logic                  aborted,
    output logic [ITER_WIDTH-1:0] iter_count
);

    state_t                state_reg, state_next;
    logic [2:0]            op_reg, op_next;
    logic [ITER_WIDTH-1:0] iterations_reg, iterations_next;
    logic [ITER_WIDTH-1:0] iter_count_reg, iter_count_next;
    logic [1:0]            store_mask_reg, store_mask_next;
    logic [CHANNELS-1:0]   channel_en_reg, channel_en_next;
    logic                  abort_reg, abort_next;
    logic                  done_reg, done_next;
    logic                  aborted_reg, aborted_next;

    logic                  engines_busy;
    logic [ITER_WIDTH:0]   passes;
    logic [2:0]            follow_op;
    logic                  abort_seen;

    always_comb begin
        engines_busy = |(bps_stall & channel_en_reg);
    end

    // One extra bit so iterations = all-ones terminates instead of wrapping.
    always_comb begin
        passes    = {1'b0, iter_count_reg} + (ITER_WIDTH+1)'(1);
        follow_op = OP_IDLE;
        case (op_reg)
            OP_LOAD:       follow_op = (iterations_reg != '0) ? OP_DOWN : first_store(store_mask_reg);
            OP_DOWN:       follow_op = OP_UP;
            OP_UP:         follow_op = (passes < {1'b0, iterations_reg}) ? OP_DOWN
                                                                         : first_store(store_mask_reg);
            OP_STORE_DOWN: follow_op = store_mask_reg[1] ? OP_STORE_UP : OP_IDLE;
            default:       follow_op = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            op_reg         <= OP_IDLE;
            iterations_reg <= '0;
            iter_count_reg <= '0;
            store_mask_reg <= '0;
            channel_en_reg <= '0;
            abort_reg      <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            iterations_reg <= iterations_next;
            iter_count_reg <= iter_count_next;
            store_mask_reg <= store_mask_next;
            channel_en_reg <= channel_en_next;
            abort_reg      <= abort_next;
            done_reg       <= done_next;
            aborted_reg    <= aborted_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        iterations_next = iterations_reg;
        iter_count_next = iter_count_reg;
        store_mask_next = store_mask_reg;
        channel_en_next = channel_en_reg;
        done_next       = 1'b0;
        aborted_next    = 1'b0;
        abort_seen      = abort_reg | abort;
        abort_next      = abort_seen;

        case (state_reg)
            ST_IDLE: begin
                abort_next = 1'b0;
                if (start && !abort) begin
                    iterations_next = iterations;
                    store_mask_next = store_mask;
                    channel_en_next = channel_en;
                    iter_count_next = '0;
                    op_next         = OP_LOAD;
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_BLANK;
            ST_BLANK: state_next = ST_WAIT;
            ST_WAIT: begin
                if (!engines_busy) begin
                    if (op_reg == OP_UP)
                        iter_count_next = passes[ITER_WIDTH-1:0];
                    // A pending abort lets the current op finish, then drops all remaining ops.
                    if (abort_seen || follow_op == OP_IDLE) begin
                        state_next   = ST_IDLE;
                        done_next    = 1'b1;
                        aborted_next = abort_seen;
                        abort_next   = 1'b0;
                    end else begin
                        op_next    = follow_op;
                        state_next = ST_ISSUE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign opcode     = (state_reg == ST_ISSUE) ? op_reg : OP_IDLE;
    assign stall      = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign aborted    = aborted_reg;
    assign iter_count = iter_count_reg;

endmodule

// File: tb/tb_bps_sequencer.sv
// Directed bench for bps_sequencer: table of whole jobs plus hand-written
// back-to-back, reset and start/abort sequences.
module tb_bps_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] iterations;
    logic [1:0] store_mask;
    logic [3:0] channel_en;
    logic [3:0] bps_stall;
    logic       stall;
    logic [2:0] opcode;
    logic       done;
    logic       aborted;
    logic [7:0] iter_count;

    int compared = 0;
    int failed   = 0;

    bps_sequencer #(.CHANNELS(4), .ITER_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .iterations (iterations),
        .store_mask (store_mask),
        .channel_en (channel_en),
        .bps_stall  (bps_stall),
        .stall      (stall),
        .opcode     (opcode),
        .done       (done),
        .aborted    (aborted),
        .iter_count (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle k = 1 is the first cycle after the start edge (the LOAD issue cycle).
    // Extra stall bits are driven for cycles s_from <= k < s_to; abort pulses in cycle abort_at.
    // Op k is expected in cycle 1 + 3k, plus dly for every op from index dly_op on.
    typedef struct {
        int    it;
        int    mask;
        int    en;
        int    base;
        int    extra;
        int    s_from;
        int    s_to;
        int    abort_at;
        string ops;
        int    nops;
        int    dly_op;
        int    dly;
        int    done_cyc;
        int    ab;
        int    iter;
    } job_t;

    job_t jobs[10];

    task automatic check(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic run_job(input job_t j, input int idx);
        int k;
        int n_ops;
        bit got_done;
        int done_cyc;
        int ab_seen;
        int iter_seen;
        int stall_at_done;
        int stall_gaps;
        int log_op[8];
        int log_cyc[8];
        for (int i = 0; i < 8; i++) begin
            log_op[i]  = 0;
            log_cyc[i] = 0;
        end
        k = 0; n_ops = 0; got_done = 0; done_cyc = 0;
        ab_seen = 0; iter_seen = 0; stall_at_done = 0; stall_gaps = 0;

        @(negedge clk);
        iterations = 8'(j.it);
        store_mask = 2'(j.mask);
        channel_en = 4'(j.en);
        bps_stall  = 4'(j.base);
        start      = 1'b1;
        while (!got_done && k < j.done_cyc + 20) begin
            @(negedge clk);
            k++;
            start     = 1'b0;
            abort     = (k == j.abort_at);
            bps_stall = 4'(j.base) | ((k >= j.s_from && k < j.s_to) ? 4'(j.extra) : 4'h0);
            if (opcode != 3'd0) begin
                if (n_ops < 8) begin
                    log_op[n_ops]  = int'(opcode);
                    log_cyc[n_ops] = k;
                end
                n_ops++;
            end
            if (done) begin
                got_done      = 1'b1;
                done_cyc      = k;
                ab_seen       = int'(aborted);
                iter_seen     = int'(iter_count);
                stall_at_done = int'(stall);
            end else if (!stall) begin
                stall_gaps++;
            end
        end

        if (!got_done) begin
            compared++;
            failed++;
            $display("FAIL job%0d_timeout: no done within %0d cycles, expected done at cycle %0d",
                     idx, k, j.done_cyc);
        end else begin
            for (int i = 0; i < j.ops.len(); i++) begin
                check($sformatf("job%0d_op%0d_code", idx, i), log_op[i], int'(j.ops[i]) - 48);
                check($sformatf("job%0d_op%0d_cycle", idx, i), log_cyc[i],
                      1 + 3 * i + ((i >= j.dly_op) ? j.dly : 0));
            end
            check($sformatf("job%0d_op_count", idx), n_ops, j.nops);
            check($sformatf("job%0d_done_cycle", idx), done_cyc, j.done_cyc);
            check($sformatf("job%0d_aborted", idx), ab_seen, j.ab);
            check($sformatf("job%0d_iter_count", idx), iter_seen, j.iter);
            check($sformatf("job%0d_stall_at_done", idx), stall_at_done, 0);
            check($sformatf("job%0d_stall_gaps", idx), stall_gaps, 0);
        end
        abort     = 1'b0;
        bps_stall = 4'h0;
        @(negedge clk);
        check($sformatf("job%0d_done_pulse_width", idx), done, 0);
        check($sformatf("job%0d_iter_hold", idx), iter_count, j.iter);
    endtask

    initial begin
        int k;
        int seen_done;

        //          it  mask en  base extra from to  abort ops         nops dly_op dly done  ab iter
        jobs[0] = '{2,   3, 15, 0,   0,    0,   0,  0,  "1232345",  7,   99,    0,  22,   0, 2};
        jobs[1] = '{0,   2, 15, 0,   0,    0,   0,  0,  "15",       2,   99,    0,  7,    0, 0};
        jobs[2] = '{1,   0, 15, 0,   0,    0,   0,  0,  "123",      3,   99,    0,  10,   0, 1};
        jobs[3] = '{0,   0, 0,  15,  0,    0,   0,  0,  "1",        1,   99,    0,  4,    0, 0};
        jobs[4] = '{1,   0, 5,  2,   4,    4,   9,  0,  "123",      3,   2,     3,  13,   0, 1};
        jobs[5] = '{5,   3, 15, 0,   0,    0,   0,  9,  "123",      3,   99,    0,  10,   1, 1};
        jobs[6] = '{3,   1, 15, 0,   0,    0,   0,  0,  "12323234", 8,   99,    0,  25,   0, 3};
        jobs[7] = '{255, 3, 15, 0,   0,    0,   0,  0,  "12323232", 513, 99,    0,  1540, 0, 255};
        jobs[8] = '{0,   1, 15, 0,   8,    1,   6,  0,  "14",       2,   1,     3,  10,   0, 0};
        jobs[9] = '{0,   1, 15, 0,   8,    2,   3,  0,  "14",       2,   99,    0,  7,    0, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        iterations = 8'd0; store_mask = 2'd0; channel_en = 4'h0; bps_stall = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_opcode", opcode, 0);
        check("reset_stall", stall, 0);
        check("reset_done", done, 0);
        check("reset_aborted", aborted, 0);
        check("reset_iter_count", iter_count, 0);
        rst = 1'b0;

        for (int j = 0; j < 10; j++)
            run_job(jobs[j], j);

        // Back-to-back: restart in the done cycle, ignore a busy start, then reset mid-DOWN.
        @(negedge clk);
        iterations = 8'd2; store_mask = 2'd0; channel_en = 4'hF; start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start = 1'b0;
        end while (!done && k < 40);
        check("b2b_first_done", done, 1);
        check("b2b_first_done_cycle", k, 16);
        start = 1'b1;
        @(negedge clk);
        check("b2b_restart_load", opcode, 1);
        check("b2b_restart_stall", stall, 1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_down", opcode, 2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_start_ignored_up", opcode, 3);
        repeat (3) @(negedge clk);
        check("mid_job_second_down", opcode, 2);
        check("mid_job_iter_count", iter_count, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_opcode", opcode, 0);
        check("async_reset_stall", stall, 0);
        check("async_reset_iter_count", iter_count, 0);
        check("async_reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("reset_no_done_pulse", seen_done, 0);
        check("reset_stays_idle", stall, 0);

        // start with abort in IDLE must not launch a job
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_no_stall", stall, 0);
        check("start_abort_no_opcode", opcode, 0);
        @(negedge clk);
        check("start_abort_still_idle", stall, 0);

        // abort in IDLE is not sticky: a following job runs to completion unaborted
        run_job(jobs[2], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
